// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state, error-code and width definitions for the divider front end
package div_pkg;
  localparam int DIVISOR_W  = 8;
  localparam int DIVIDEND_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DZ  = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
endpackage

// File: rtl/div_wdog.sv
// rtl/div_wdog.sv - loadable down-counter with clear; expired while the count sits at zero
module div_wdog #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (!Reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - operand screening, start pulse, done watchdog and result return
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVISOR_W-1:0]  in_a,
  input  logic [DIVIDEND_W-1:0] in_b,
  output logic                  div_start,
  output logic [DIVISOR_W-1:0]  div_a,
  output logic [DIVIDEND_W-1:0] div_b,
  input  logic                  div_done,
  input  logic [7:0]            div_q,
  input  logic [7:0]            div_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_q,
  output logic [7:0]            out_r,
  output logic [1:0]            out_err,
  output logic                  busy
);
  localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // START holds for START_CYCLES edges: load N-1 so the edge that sees zero leaves.
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(TIMEOUT);

  state_t                  state, state_nxt;
  logic [DIVISOR_W-1:0]    a_nxt;
  logic [DIVIDEND_W-1:0]   b_nxt;
  logic                    start_nxt, valid_nxt;
  logic [7:0]              q_nxt, r_nxt;
  logic [1:0]              err_nxt;
  logic                    wd_clear, wd_load, wd_expired;
  logic [CNT_W-1:0]        wd_load_val;

  div_wdog #(.W(CNT_W)) u_wdog (
    .CLK      (CLK),
    .Reset    (Reset),
    .clear    (wd_clear),
    .load     (wd_load),
    .load_val (wd_load_val),
    .expired  (wd_expired)
  );

  always_comb begin
    state_nxt   = state;
    a_nxt       = div_a;
    b_nxt       = div_b;
    start_nxt   = 1'b0;
    valid_nxt   = out_valid;
    q_nxt       = out_q;
    r_nxt       = out_r;
    err_nxt     = out_err;
    wd_clear    = 1'b0;
    wd_load     = 1'b0;
    wd_load_val = START_LOAD;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt = in_a;
          b_nxt = in_b;
          if (in_a == '0) begin
            err_nxt   = ERR_DZ;
            q_nxt     = '0;
            r_nxt     = '0;
            valid_nxt = 1'b1;
            state_nxt = S_RESP;
          end else if (in_b[15:8] >= in_a) begin
            err_nxt   = ERR_OVF;
            q_nxt     = '0;
            r_nxt     = '0;
            valid_nxt = 1'b1;
            state_nxt = S_RESP;
          end else begin
            start_nxt = 1'b1;
            wd_load   = 1'b1;
            state_nxt = S_START;
          end
        end
      end
      S_START: begin
        if (wd_expired) begin
          wd_load     = 1'b1;
          wd_load_val = TMO_LOAD;
          state_nxt   = S_WAIT;
        end else begin
          start_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        // done is checked first so it wins over a same-cycle timeout
        if (div_done) begin
          q_nxt     = div_q;
          r_nxt     = div_r;
          err_nxt   = ERR_OK;
          valid_nxt = 1'b1;
          wd_clear  = 1'b1;
          state_nxt = S_RESP;
        end else if (wd_expired) begin
          q_nxt     = '0;
          r_nxt     = '0;
          err_nxt   = ERR_TMO;
          valid_nxt = 1'b1;
          wd_clear  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_err   <= ERR_OK;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      div_start <= start_nxt;
      div_a     <= a_nxt;
      div_b     <= b_nxt;
      out_valid <= valid_nxt;
      out_q     <= q_nxt;
      out_r     <= r_nxt;
      out_err   <= err_nxt;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [15:0] in_b = '0;
  logic        div_start;
  logic [7:0]  div_a;
  logic [15:0] div_b;
  logic        div_done = 1'b0;
  logic [7:0]  div_q = '0;
  logic [7:0]  div_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_q;
  logic [7:0]  out_r;
  logic [1:0]  out_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  div_issue_ctrl #(.START_CYCLES(2), .TIMEOUT(64)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_done  (div_done),
    .div_q     (div_q),
    .div_r     (div_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // offers one operand pair and returns observing the cycle after acceptance
  task automatic accept(input logic [7:0] a, input logic [15:0] b);
    int k = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({div_start, out_valid, busy, in_ready} !== 4'b0000 || out_q !== 8'd0 || out_r !== 8'd0 ||
        out_err !== 2'b00 || div_a !== 8'd0 || div_b !== 16'd0) begin
      n_fail++;
      $display("FAIL %s start=%b valid=%b busy=%b ready=%b q=%0d r=%0d err=%b a=%0d b=%0d want all zero",
               tag, div_start, out_valid, busy, in_ready, out_q, out_r, out_err, div_a, div_b);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    check_reset_values("reset_state");
    Reset = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_normal(input logic [7:0] a, input logic [15:0] b, input int delay,
                             input logic [7:0] eq, input logic [7:0] er, input logic early);
    logic bad = 1'b0;
    out_ready = early;
    accept(a, b);
    n_tests++;
    if (div_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || div_a !== a || div_b !== b) begin
      n_fail++;
      $display("FAIL norm_t1 start=%b busy=%b ready=%b a=%0d b=%0d want 1 1 0 %0d %0d",
               div_start, busy, in_ready, div_a, div_b, a, b);
    end
    tick();
    n_tests++;
    if (div_start !== 1'b1) begin
      n_fail++;
      $display("FAIL norm_start_t2 got %b want 1", div_start);
    end
    tick();
    n_tests++;
    if (div_start !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL norm_wait_entry start=%b valid=%b want 0 0", div_start, out_valid);
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      if (out_valid !== 1'b0 || div_a !== a || div_b !== b) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL norm_wait_quiet early valid or unstable operands, want valid=0");
    end
    div_done = 1'b1;
    div_q = 8'(b / 16'(a));
    div_r = 8'(b % 16'(a));
    tick();
    div_done = 1'b0;
    div_q = '0;
    div_r = '0;
    n_tests++;
    if (out_valid !== 1'b1 || out_q !== eq || out_r !== er || out_err !== 2'b00) begin
      n_fail++;
      $display("FAIL norm_result valid=%b q=%0d r=%0d err=%b want 1 %0d %0d 00",
               out_valid, out_q, out_r, out_err, eq, er);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL norm_handshake valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    accept(8'd0, 16'd500);
    n_tests++;
    if (out_valid !== 1'b1 || out_err !== 2'b01 || out_q !== 8'd0 || out_r !== 8'd0 ||
        div_start !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_t1 valid=%b err=%b q=%0d r=%0d start=%b ready=%b want 1 01 0 0 0 0",
               out_valid, out_err, out_q, out_r, div_start, in_ready);
    end
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_after ready=%b valid=%b start=%b want 1 0 0", in_ready, out_valid, div_start);
    end
  endtask

  task automatic test_overflow_stall();
    logic bad = 1'b0;
    out_ready = 1'b0;
    accept(8'd3, 16'h0400);
    n_tests++;
    if (out_valid !== 1'b1 || out_err !== 2'b10 || out_q !== 8'd0 || out_r !== 8'd0 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_t1 valid=%b err=%b q=%0d r=%0d start=%b want 1 10 0 0 0",
               out_valid, out_err, out_q, out_r, div_start);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_err !== 2'b10 || out_q !== 8'd0 || out_r !== 8'd0 ||
          in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL ovf_stall outputs moved or in_ready rose while out_ready low, want held");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_release valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    logic bad = 1'b0;
    out_ready = 1'b0;
    div_done = 1'b1;
    tick();
    accept(8'd7, 16'd1000);
    tick();
    tick();
    div_done = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || div_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_stale_done valid=%b start=%b busy=%b want 0 0 1", out_valid, div_start, busy);
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL tmo_early out_valid rose before WAIT+65, want 0");
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_err !== 2'b11 || out_q !== 8'd0 || out_r !== 8'd0) begin
      n_fail++;
      $display("FAIL tmo_result valid=%b err=%b q=%0d r=%0d want 1 11 0 0", out_valid, out_err, out_q, out_r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    out_ready = 1'b0;
    accept(8'd7, 16'd1000);
    tick();
    tick();
    tick();
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check_reset_values("reset_mid_wait");
    test_normal(8'd7, 16'd1000, 17, 8'd142, 8'd6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal(8'd7, 16'd1000, 17, 8'd142, 8'd6, 1'b0);
    test_div_zero();
    test_overflow_stall();
    test_normal(8'd5, 16'h04FF, 3, 8'd255, 8'd4, 1'b1);
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit bench did not finish within 200000 time units");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Request/response front end for the 8-bit-divisor / 16-bit-dividend sequential divider. It accepts operand pairs over a valid/ready handshake and screens out divide-by-zero and quotient-overflow cases without running the divider. Valid pairs drive the divider operands, pulse its start input, and wait for its done flag with a watchdog. Quotient, remainder and an error code return over a second valid/ready handshake. It sits directly upstream of the divider and also consumes the divider's outputs.

## Interface
- `START_CYCLES`, default 2: cycles `div_start` is held high (≥1).
- `TIMEOUT`, default 64: maximum cycles spent waiting for `div_done` before a timeout error (≥2).
- `CLK`  input  1: single clock, rising edge.
- `Reset`  input  1: synchronous, active-low reset.
- `in_valid`  input  1: operand pair offered.
- `in_ready`  output  1: controller can accept an operand pair.
- `in_a`  input  8: divisor.
- `in_b`  input  16: dividend.
- `div_start`  output  1: start/clear to the divider.
- `div_a`  output  8: divisor to the divider.
- `div_b`  output  16: dividend to the divider.
- `div_done`  input  1: divider finished.
- `div_q`  input  8: divider quotient.
- `div_r`  input  8: divider remainder.
- `out_valid`  output  1: result available.
- `out_ready`  input  1: consumer accepts the result.
- `out_q`  output  8: quotient.
- `out_r`  output  8: remainder.
- `out_err`  output  2: result status. 00 = ok, 01 = divide-by-zero, 10 = overflow, 11 = timeout.
- `busy`  output  1: high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1, latch `in_a`/`in_b` into the operand registers.
  - If `in_a`==0: set err=01, q=r=0, go to RESP.
  - Else if `in_b[15:8]` ≥ `in_a` (quotient would not fit in 8 bits): set err=10, q=r=0, go to RESP.
  - Else: go to START.
- `div_a`/`div_b` always come from the operand registers. They stay stable from acceptance until return to IDLE.
- START:
  - `div_start`=1 for exactly `START_CYCLES` cycles, counted by an internal counter.
  - Then go to WAIT and clear the watchdog.
- WAIT:
  - `div_done` is honoured only in this state. A stale `div_done` seen in IDLE, START or RESP is ignored.
  - First cycle with `div_done`=1: capture `div_q`/`div_r`, set err=00, go to RESP.
  - Watchdog counts WAIT cycles. If it reaches `TIMEOUT` with no done: set err=11, q=r=0, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `out_valid`=1. `out_q`/`out_r`/`out_err` are held stable until `out_ready`=1.
  - The handshake completes in any cycle with both signals high, including the first RESP cycle. Then go to IDLE.
- One operation in flight. `in_ready`=0 outside IDLE. No input buffering.
- Reset (`Reset`=0 at a clock edge), from any state:
  - State goes to IDLE; all counters clear.
  - `div_start`=0, `out_valid`=0, `busy`=0, `in_ready`=0 during reset.
  - `out_q`/`out_r`/`div_a`/`div_b`=0, `out_err`=00.
  - Any operation in progress is discarded with no response.

## Timing
- Acceptance edge = T.
- Error path (01/10): `out_valid` at T+1. `div_start` is never asserted.
- Normal path:
  - `div_start` high in cycles T+1 … T+`START_CYCLES`.
  - WAIT begins at T+`START_CYCLES`+1.
  - If `div_done` is first sampled in cycle W, `out_valid` is asserted in W+1.
- Timeout: `out_valid` exactly `TIMEOUT`+1 cycles after WAIT begins.
- After the output handshake at edge H, `in_ready`=1 from H+1. Minimum gap between acceptances is therefore 2 cycles on the error path.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `div_pkg` holds:
  - the state enum;
  - error-code constants `ERR_OK`, `ERR_DZ`, `ERR_OVF`, `ERR_TMO`;
  - width constants `DIVISOR_W`=8 and `DIVIDEND_W`=16.
- Sub-module `div_wdog` is a loadable down-counter with clear and an expiry flag. It serves both the START pulse length and the WAIT timeout.
- The main FSM and its registers stay in `div_issue_ctrl`.

## Test plan
- a=7, b=1000, with the bench divider model answering after 17 cycles: `div_start` high 2 cycles, then out q=142, r=6, err=00.
- a=0, b=500: out_valid at T+1, err=01, q=r=0, `div_start` never high.
- a=3, b=0x0400: err=10 at T+1; a=5, b=0x04FF: valid, q=255, r=4.
- Model never asserts done: err=11 exactly 65 cycles after WAIT entry. Stale `div_done`=1 held through START is ignored.
- `out_ready` held low 5 cycles: outputs stable and `in_ready`=0 throughout. With `out_ready` high in the first RESP cycle, `in_ready` rises on the next cycle.
- `Reset`=0 for one cycle mid-WAIT: next cycle all outputs at reset values. A subsequent a=7, b=1000 completes correctly.
